mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port memory with one-cycle read latency.
// Define MEM_ARB_STARVE_GUARD_EN to let fetch win one grant after STARVE_LIMIT data grants.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [31:0]           i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [1:0]            d_width,
   input  logic                  d_usignext,
   input  logic [31:0]           d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [31:0]           d_rdata,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [1:0]            mem_width,
   output logic                  mem_usignext,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   typedef enum logic [1:0] {OwnNone, OwnIfetch, OwnData} owner_e;

   owner_e owner_q, owner_d;
   logic   we_q, we_d;
   logic   ready_q, ready_d;
   logic   gnt_en;
   logic   fetch_pri;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);
   localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign fetch_pri = (cnt_q == Limit);

   always_comb begin
      cnt_d = cnt_q;
      if (!i_req || i_gnt) begin
         cnt_d = '0;
      end else if (d_gnt) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic unused_starve_limit;
   assign unused_starve_limit = ^STARVE_LIMIT;
   assign fetch_pri = 1'b0;
`endif

   // Grants stay off while reset is low and for the first cycle after release.
   assign gnt_en = reset & ready_q;

   always_comb begin
      i_gnt        = 1'b0;
      d_gnt        = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_width    = 2'b00;
      mem_usignext = 1'b0;
      mem_wdata    = '0;
      if (gnt_en) begin
         if (i_req && (fetch_pri || !d_req)) begin
            i_gnt = 1'b1;
         end else if (d_req) begin
            d_gnt = 1'b1;
         end
      end
      if (i_gnt) begin
         mem_addr  = i_addr;
         mem_width = 2'b10;
      end else if (d_gnt) begin
         mem_we       = d_we;
         mem_addr     = d_addr;
         mem_width    = d_width;
         mem_usignext = d_usignext;
         mem_wdata    = d_wdata;
      end
   end

   always_comb begin
      owner_d = OwnNone;
      if (d_gnt) begin
         owner_d = OwnData;
      end else if (i_gnt) begin
         owner_d = OwnIfetch;
      end
      we_d    = d_gnt & d_we;
      ready_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         owner_q <= OwnNone;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         owner_q <= owner_d;
         we_q    <= we_d;
         ready_q <= ready_d;
      end
   end

   // Gating with reset drops a response whose access was in flight when reset hit.
   always_comb begin
      i_rvalid = reset && (owner_q == OwnIfetch);
      d_rvalid = reset && (owner_q == OwnData);
      i_rdata  = i_rvalid ? mem_rdata : '0;
      d_rdata  = (d_rvalid && !we_q) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter, plus starvation and alternating-request sequences.
module tb_mem_arbiter;

   localparam int unsigned StarveLimit = 4;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [1:0]  d_width;
   logic        d_usignext;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [1:0]  mem_width;
   logic        mem_usignext;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   mem_arbiter #(
      .ADDR_WIDTH  (32),
      .STARVE_LIMIT(StarveLimit)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_req       (i_req),
      .i_addr      (i_addr),
      .i_gnt       (i_gnt),
      .i_rvalid    (i_rvalid),
      .i_rdata     (i_rdata),
      .d_req       (d_req),
      .d_we        (d_we),
      .d_addr      (d_addr),
      .d_width     (d_width),
      .d_usignext  (d_usignext),
      .d_wdata     (d_wdata),
      .d_gnt       (d_gnt),
      .d_rvalid    (d_rvalid),
      .d_rdata     (d_rdata),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_width   (mem_width),
      .mem_usignext(mem_usignext),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ir;
      logic [31:0] ia;
      logic        dr;
      logic        dwe;
      logic [31:0] da;
      logic [1:0]  dw;
      logic        dus;
      logic [31:0] dwd;
      logic [31:0] mrd;
      logic        eig;
      logic        edg;
      logic        eiv;
      logic        edv;
      logic [31:0] eird;
      logic [31:0] edrd;
      logic        emwe;
      logic [31:0] ema;
      logic [1:0]  emw;
      logic        emus;
      logic [31:0] emwd;
   } vec_t;

   int n_vec;
   int n_err;

   function automatic logic [135:0] pack_outs(
      logic ig, logic dg, logic iv, logic dv, logic [31:0] ird, logic [31:0] drd,
      logic mwe, logic [31:0] ma, logic [1:0] mw, logic mus, logic [31:0] mwd);
      return {ig, dg, iv, dv, ird, drd, mwe, ma, mw, mus, mwd};
   endfunction

   function automatic logic [135:0] dut_outs();
      return pack_outs(i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata,
                       mem_we, mem_addr, mem_width, mem_usignext, mem_wdata);
   endfunction

   task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic ir, input logic [31:0] ia, input logic dr,
                        input logic dwe, input logic [31:0] da, input logic [1:0] dw,
                        input logic dus, input logic [31:0] dwd, input logic [31:0] mrd);
      reset      = rst;
      i_req      = ir;
      i_addr     = ia;
      d_req      = dr;
      d_we       = dwe;
      d_addr     = da;
      d_width    = dw;
      d_usignext = dus;
      d_wdata    = dwd;
      mem_rdata  = mrd;
   endtask

   vec_t vecs[16];

   initial begin
      logic [3:0] exp4;
      logic [3:0] act4;
      logic       prev_ig;
      logic       prev_dg;
      int         cnt;
      n_vec = 0;
      n_err = 0;

      //          rst  ir  ia     dr  dwe da        dw     dus  dwd           mrd
      //          eig  edg eiv edv eird          edrd          emwe ema    emw    emus emwd
      vecs[0]  = '{0, 1, 32'h100, 1, 0, 32'h2000, 2'b10, 0, 32'h0, 32'h55,
                   0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0};
      vecs[1]  = '{1, 1, 32'h100, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h55,
                   0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0};
      vecs[2]  = '{1, 1, 32'h100, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h0,
                   1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h100, 2'b10, 0, 32'h0};
      vecs[3]  = '{1, 0, 32'h0, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h00500093,
                   0, 0, 1, 0, 32'h00500093, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0};
      vecs[4]  = '{1, 1, 32'h104, 1, 0, 32'h2000, 2'b10, 0, 32'h0, 32'h11,
                   0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h2000, 2'b10, 0, 32'h0};
      vecs[5]  = '{1, 1, 32'h104, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'hCAFEF00D,
                   1, 0, 0, 1, 32'h0, 32'hCAFEF00D, 0, 32'h104, 2'b10, 0, 32'h0};
      vecs[6]  = '{1, 0, 32'h0, 1, 1, 32'h2004, 2'b00, 0, 32'hDEADBEEF, 32'h12345678,
                   0, 1, 1, 0, 32'h12345678, 32'h0, 1, 32'h2004, 2'b00, 0, 32'hDEADBEEF};
      vecs[7]  = '{1, 0, 32'h0, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h99999999,
                   0, 0, 0, 1, 32'h0, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0};
      vecs[8]  = '{1, 0, 32'h0, 1, 0, 32'h3001, 2'b01, 1, 32'h0, 32'h0,
                   0, 1, 0, 0, 32'h0, 32'h0, 0, 32'h3001, 2'b01, 1, 32'h0};
      vecs[9]  = '{1, 0, 32'h0, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h0000ABCD,
                   0, 0, 0, 1, 32'h0, 32'h0000ABCD, 0, 32'h0, 2'b00, 0, 32'h0};
      vecs[10] = '{1, 0, 32'h0, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h77,
                   0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0};
      // Reset lands while a fetch response is in flight.
      vecs[11] = '{1, 1, 32'h200, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h0,
                   1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h200, 2'b10, 0, 32'h0};
      vecs[12] = '{0, 1, 32'h200, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h1234,
                   0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0};
      vecs[13] = '{1, 1, 32'h200, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h1234,
                   0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0};
      vecs[14] = '{1, 1, 32'h200, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h0,
                   1, 0, 0, 0, 32'h0, 32'h0, 0, 32'h200, 2'b10, 0, 32'h0};
      vecs[15] = '{1, 0, 32'h0, 0, 0, 32'h0, 2'b00, 0, 32'h0, 32'h4321,
                   0, 0, 1, 0, 32'h4321, 32'h0, 0, 32'h0, 2'b00, 0, 32'h0};

      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;

      for (int k = 0; k < 16; k++) begin
         drive(vecs[k].rst, vecs[k].ir, vecs[k].ia, vecs[k].dr, vecs[k].dwe, vecs[k].da,
               vecs[k].dw, vecs[k].dus, vecs[k].dwd, vecs[k].mrd);
         #4;
         check($sformatf("row%0d", k), dut_outs(),
               pack_outs(vecs[k].eig, vecs[k].edg, vecs[k].eiv, vecs[k].edv, vecs[k].eird,
                         vecs[k].edrd, vecs[k].emwe, vecs[k].ema, vecs[k].emw, vecs[k].emus,
                         vecs[k].emwd));
         @(posedge clk);
         #1;
      end

      // Both requests held: data wins unless the guard build forces a fetch turn.
      cnt     = 0;
      prev_ig = 1'b0;
      prev_dg = 1'b0;
      for (int k = 0; k < 12; k++) begin
         logic exp_ig;
`ifdef MEM_ARB_STARVE_GUARD_EN
         exp_ig = (cnt == StarveLimit);
         cnt    = exp_ig ? 0 : cnt + 1;
`else
         exp_ig = 1'b0;
`endif
         drive(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h2000, 2'b10, 1'b0, 32'h0, 32'hA5A5A5A5);
         #4;
         exp4 = {exp_ig, ~exp_ig, prev_ig, prev_dg};
         act4 = {i_gnt, d_gnt, i_rvalid, d_rvalid};
         check($sformatf("starve%0d", k), {132'h0, act4}, {132'h0, exp4});
         prev_ig = exp_ig;
         prev_dg = ~exp_ig;
         @(posedge clk);
         #1;
      end

      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;

      // Continuous fetch with single-cycle data requests interleaved.
      prev_ig = 1'b0;
      prev_dg = 1'b0;
      for (int k = 0; k < 12; k++) begin
         logic dr;
         dr = (k % 2 == 0);
         drive(1'b1, 1'b1, 32'h400 + 32'(4 * k), dr, 1'b0, 32'h5000, 2'b10, 1'b0, 32'h0,
               32'h1000 + 32'(k));
         #4;
         exp4 = {~dr, dr, prev_ig, prev_dg};
         act4 = {i_gnt, d_gnt, i_rvalid, d_rvalid};
         check($sformatf("alt%0d", k), {132'h0, act4}, {132'h0, exp4});
         prev_ig = ~dr;
         prev_dg = dr;
         @(posedge clk);
         #1;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
